// File: rtl/ualink_dpmem_pkg.sv
// Shared defaults, requester ids and small helpers for the dual-requester
// RAM port arbiter.
package ualink_dpmem_pkg;

  localparam int DPADDR_WIDTH_DEF = 8;
  localparam int DPDATA_WIDTH_DEF = 64;
  localparam int NUM_REQ          = 2;
  localparam int LOCK_MAX_DEF     = 4;
  localparam int LOCK_CNT_W       = 4;

  typedef enum logic {
    REQ_R0 = 1'b0,
    REQ_R1 = 1'b1
  } req_id_e;

  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_state_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_R0) ? REQ_R1 : REQ_R0;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ualink_dpmem_arb_if.sv
// Request/response bundle for both requesters of the RAM port arbiter.
interface ualink_dpmem_arb_if
  import ualink_dpmem_pkg::*;
#(
  parameter int DPADDR_WIDTH = DPADDR_WIDTH_DEF,
  parameter int DPDATA_WIDTH = DPDATA_WIDTH_DEF
);
  logic                    r0_req_valid, r1_req_valid;
  logic                    r0_req_ready, r1_req_ready;
  logic                    r0_req_we,    r1_req_we;
  logic                    r0_req_lock,  r1_req_lock;
  logic [DPADDR_WIDTH-1:0] r0_req_addr,  r1_req_addr;
  logic [DPDATA_WIDTH-1:0] r0_req_wdata, r1_req_wdata;
  logic                    r0_rsp_valid, r1_rsp_valid;
  logic [DPDATA_WIDTH-1:0] r0_rsp_rdata, r1_rsp_rdata;
  logic [15:0]             r0_grant_cnt, r1_grant_cnt;

  modport slave (
    input  r0_req_valid, r1_req_valid, r0_req_we, r1_req_we,
           r0_req_lock, r1_req_lock, r0_req_addr, r1_req_addr,
           r0_req_wdata, r1_req_wdata,
    output r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
           r0_rsp_rdata, r1_rsp_rdata, r0_grant_cnt, r1_grant_cnt
  );

  modport master (
    output r0_req_valid, r1_req_valid, r0_req_we, r1_req_we,
           r0_req_lock, r1_req_lock, r0_req_addr, r1_req_addr,
           r0_req_wdata, r1_req_wdata,
    input  r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
           r0_rsp_rdata, r1_rsp_rdata, r0_grant_cnt, r1_grant_cnt
  );

endinterface

// File: rtl/ualink_rr_arb2.sv
// Two-requester round-robin arbiter with bounded grant locking.
//
// state   | meaning
// LK_FREE | no lock held; contention resolved by the round-robin pointer
// LK_HELD | last accept asked to lock; owner keeps the grant until it drops
//         | valid, accepts unlocked, or has taken LOCK_MAX beats under contention
module ualink_rr_arb2
  import ualink_dpmem_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic               axi_aclk,
  input  logic               axi_resetn,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_lock,
  output logic               gnt_valid,
  output req_id_e            gnt_id
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(LOCK_MAX);
  localparam logic [LOCK_CNT_W-1:0] CNT_SAT    = '1;

  lock_state_e            state_q, state_d;
  req_id_e                ptr_q, ptr_d;
  req_id_e                owner_q, owner_d;
  logic [LOCK_CNT_W-1:0]  cnt_q, cnt_d;

  // State register: pointer, lock owner and consecutive locked-beat count.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= LK_FREE;
      ptr_q   <= REQ_R0;
      owner_q <= REQ_R0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Winner selection and next-state; a sole valid requester always wins.
  always_comb begin
    gnt_valid = |req_valid;
    gnt_id    = ptr_q;
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;

    if (state_q == LK_HELD && req_valid[owner_q]) begin
      if (cnt_q >= LOCK_LIMIT && req_valid[other_req(owner_q)])
        gnt_id = other_req(owner_q);
      else
        gnt_id = owner_q;
    end else if (req_valid[ptr_q]) begin
      gnt_id = ptr_q;
    end else begin
      gnt_id = other_req(ptr_q);
    end

    if (state_q == LK_HELD && !req_valid[owner_q]) begin
      state_d = LK_FREE;
      cnt_d   = '0;
    end

    if (gnt_valid) begin
      if (req_lock[gnt_id]) begin
        state_d = LK_HELD;
        owner_d = gnt_id;
        if (state_q == LK_HELD && owner_q == gnt_id)
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        else
          cnt_d = LOCK_CNT_W'(1);
      end else begin
        state_d = LK_FREE;
        cnt_d   = '0;
        ptr_d   = other_req(gnt_id);
      end
    end
  end

endmodule

// File: rtl/ualink_dpmem_arb.sv
// Shares one synchronous RAM port between two requesters: arbitration,
// registered RAM drive, a two-stage response tag pipe and grant counters.
module ualink_dpmem_arb
  import ualink_dpmem_pkg::*;
#(
  parameter int DPADDR_WIDTH = DPADDR_WIDTH_DEF,
  parameter int DPDATA_WIDTH = DPDATA_WIDTH_DEF,
  parameter int LOCK_MAX     = LOCK_MAX_DEF
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  ualink_dpmem_arb_if.slave       bus,
  output logic                    ram_we,
  output logic [DPADDR_WIDTH-1:0] ram_addr,
  output logic [DPDATA_WIDTH-1:0] ram_din,
  input  logic [DPDATA_WIDTH-1:0] ram_dout
);

  logic                    gnt_valid;
  req_id_e                 gnt_id;
  logic                    accept;
  logic                    tag_v1, tag_v2;
  req_id_e                 tag_own1, tag_own2;
  logic                    hit0, hit1;
  logic [DPDATA_WIDTH-1:0] hold0, hold1;

  ualink_rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .req_valid  ({bus.r1_req_valid, bus.r0_req_valid}),
    .req_lock   ({bus.r1_req_lock,  bus.r0_req_lock}),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Ready is gated by reset so nothing is accepted while the block is held.
  assign accept           = gnt_valid & axi_resetn;
  assign bus.r0_req_ready = accept & (gnt_id == REQ_R0);
  assign bus.r1_req_ready = accept & (gnt_id == REQ_R1);

  // Register the accepted beat onto the RAM port; idle cycles drop ram_we.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else if (accept) begin
      ram_we   <= (gnt_id == REQ_R1) ? bus.r1_req_we    : bus.r0_req_we;
      ram_addr <= (gnt_id == REQ_R1) ? bus.r1_req_addr  : bus.r0_req_addr;
      ram_din  <= (gnt_id == REQ_R1) ? bus.r1_req_wdata : bus.r0_req_wdata;
    end else begin
      ram_we   <= 1'b0;
    end
  end

  // Owner/valid tag follows each beat through RAM sampling and read latency.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      tag_v1   <= 1'b0;
      tag_v2   <= 1'b0;
      tag_own1 <= REQ_R0;
      tag_own2 <= REQ_R0;
    end else begin
      tag_v1   <= accept;
      tag_v2   <= tag_v1;
      tag_own1 <= gnt_id;
      tag_own2 <= tag_own1;
    end
  end

  assign hit0 = tag_v2 & (tag_own2 == REQ_R0);
  assign hit1 = tag_v2 & (tag_own2 == REQ_R1);

  // Hold the last delivered data so rsp_rdata stays put between strobes.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (hit0) hold0 <= ram_dout;
      if (hit1) hold1 <= ram_dout;
    end
  end

  assign bus.r0_rsp_valid = hit0;
  assign bus.r1_rsp_valid = hit1;
  assign bus.r0_rsp_rdata = hit0 ? ram_dout : hold0;
  assign bus.r1_rsp_rdata = hit1 ? ram_dout : hold1;

  // Saturating per-requester accept counters.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      bus.r0_grant_cnt <= '0;
      bus.r1_grant_cnt <= '0;
    end else if (accept) begin
      if (gnt_id == REQ_R0) bus.r0_grant_cnt <= sat_inc16(bus.r0_grant_cnt);
      else                  bus.r1_grant_cnt <= sat_inc16(bus.r1_grant_cnt);
    end
  end

endmodule

// File: tb/tb_ualink_dpmem_arb.sv
// Scoreboard bench for ualink_dpmem_arb with a write-first RAM model.
module tb_ualink_dpmem_arb;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int LM = 4;

  logic          axi_aclk;
  logic          axi_resetn;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  ualink_dpmem_arb_if #(.DPADDR_WIDTH(AW), .DPDATA_WIDTH(DW)) bus ();

  ualink_dpmem_arb #(.DPADDR_WIDTH(AW), .DPDATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .bus        (bus.slave),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  // Write-first synchronous RAM.
  logic [DW-1:0] tb_ram [256];
  always @(posedge axi_aclk) begin
    if (ram_we) tb_ram[ram_addr] <= ram_din;
    ram_dout <= ram_we ? ram_din : tb_ram[ram_addr];
  end

  typedef struct {
    int            owner;
    int            cyc;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          exp_q[$];
  int            dut_log[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [DW-1:0] mdl_mem [256];
  int            mdl_cnt [2];
  logic [DW-1:0] last_rdata [2];
  int            chain_owner = -1;
  int            chain_len = 0;
  int            rr_prio = 0;

  always @(posedge axi_aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: decides the winner from the arbitration rules, checks
  // ready and the counters, and queues the response each accept should produce.
  always @(negedge axi_aclk) begin
    logic [1:0]    v, lk, we;
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    int            w;
    rsp_t          r;
    if (!axi_resetn) begin
      chain_owner = -1; chain_len = 0; rr_prio = 0;
      mdl_cnt[0] = 0; mdl_cnt[1] = 0;
      exp_q.delete();
      chk("rst_ctl", {bus.r0_req_ready, bus.r1_req_ready, bus.r0_rsp_valid,
                      bus.r1_rsp_valid, ram_we}, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_rdata0", bus.r0_rsp_rdata, 0);
      chk("rst_rdata1", bus.r1_rsp_rdata, 0);
      chk("rst_cnt", {bus.r0_grant_cnt, bus.r1_grant_cnt}, 0);
    end else begin
      v  = {bus.r1_req_valid, bus.r0_req_valid};
      lk = {bus.r1_req_lock,  bus.r0_req_lock};
      we = {bus.r1_req_we,    bus.r0_req_we};
      a[0] = bus.r0_req_addr;  a[1] = bus.r1_req_addr;
      d[0] = bus.r0_req_wdata; d[1] = bus.r1_req_wdata;
      w = -1;
      if (v == 2'b11) begin
        if (chain_owner >= 0) w = (chain_len >= LM) ? 1 - chain_owner : chain_owner;
        else                  w = rr_prio;
      end else if (v[0]) w = 0;
      else if (v[1])     w = 1;

      chk("ready", {bus.r1_req_ready, bus.r0_req_ready}, {w == 1, w == 0});
      chk("grant_cnt0", bus.r0_grant_cnt, mdl_cnt[0]);
      chk("grant_cnt1", bus.r1_grant_cnt, mdl_cnt[1]);
      if (bus.r0_req_ready)      dut_log.push_back(0);
      else if (bus.r1_req_ready) dut_log.push_back(1);

      if (chain_owner >= 0 && !v[chain_owner]) begin
        chain_owner = -1; chain_len = 0;
      end
      if (w >= 0) begin
        r.owner = w;
        r.cyc   = cyc;
        if (we[w]) begin
          mdl_mem[a[w]] = d[w];
          r.data = d[w];
        end else begin
          r.data = mdl_mem[a[w]];
        end
        exp_q.push_back(r);
        if (mdl_cnt[w] < 65535) mdl_cnt[w] = mdl_cnt[w] + 1;
        if (lk[w]) begin
          chain_len   = (chain_owner == w) ? chain_len + 1 : 1;
          chain_owner = w;
        end else begin
          chain_owner = -1; chain_len = 0; rr_prio = 1 - w;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response strobe appears.
  always @(negedge axi_aclk) begin
    rsp_t          e;
    logic          rv;
    logic [DW-1:0] rd;
    if (!axi_resetn) begin
      last_rdata[0] = '0;
      last_rdata[1] = '0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc + 2 < cyc) begin
        e = exp_q.pop_front();
        chk("rsp_missing", 1, 0);
      end
      for (int k = 0; k < 2; k++) begin
        rv = (k == 0) ? bus.r0_rsp_valid : bus.r1_rsp_valid;
        rd = (k == 0) ? bus.r0_rsp_rdata : bus.r1_rsp_rdata;
        if (rv) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_owner", k, e.owner);
            chk("rsp_latency", cyc, e.cyc + 2);
            chk("rsp_data", rd, e.data);
            last_rdata[k] = e.data;
          end
        end else begin
          chk("rsp_hold", rd, last_rdata[k]);
        end
      end
    end
  end

  task automatic drv(input int k, input logic v, input logic we, input logic lk,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (k == 0) begin
      bus.r0_req_valid = v; bus.r0_req_we = we; bus.r0_req_lock = lk;
      bus.r0_req_addr = a;  bus.r0_req_wdata = d;
    end else begin
      bus.r1_req_valid = v; bus.r1_req_we = we; bus.r1_req_lock = lk;
      bus.r1_req_addr = a;  bus.r1_req_wdata = d;
    end
  endtask

  task automatic idle_all();
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 0, 0, 0, '0, '0);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge axi_aclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    axi_resetn = 1'b0;
    step(n);
    axi_resetn = 1'b1;
  endtask

  int e033 [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_ram[i]  = '0;
      mdl_mem[i] = '0;
    end
    ram_dout = '0;
    idle_all();
    axi_resetn = 1'b0;
    step(3);
    axi_resetn = 1'b1;

    // Sole requester r1 for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      drv(1, 1, 0, 0, AW'(i), '0);
      step();
    end
    idle_all();
    chk("sole_r1_cnt", bus.r1_grant_cnt, 10);
    step(4);

    // Reset one cycle after an accept; the in-flight beat must vanish.
    drv(0, 1, 0, 0, 8'h03, '0);
    step();
    idle_all();
    axi_resetn = 1'b0;
    #1;
    chk("rst_async_we", ram_we, 0);
    step();
    axi_resetn = 1'b1;
    drv(0, 1, 0, 0, 8'h04, '0);
    #1;
    chk("ready_after_release", bus.r0_req_ready, 1);
    step();
    idle_all();
    step(5);

    // Continuous unlocked reads from both: strict alternation, r1 first
    // because the last accept was r0.
    dut_log.delete();
    for (int i = 0; i < 8; i++) begin
      drv(0, 1, 0, 0, AW'(i), '0);
      drv(1, 1, 0, 0, AW'(i + 8), '0);
      step();
    end
    idle_all();
    chk("rr_len", dut_log.size(), 8);
    for (int i = 0; i < dut_log.size() && i < 8; i++)
      chk("rr_order", dut_log[i], (i % 2 == 0) ? 1 : 0);
    step(4);

    // Read-after-write across requesters on consecutive cycles.
    drv(0, 1, 1, 0, 8'h10, 64'hDEADBEEF00000001);
    step();
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 1, 0, 0, 8'h10, '0);
    step();
    idle_all();
    step(2);
    chk("raw_r1_rdata", bus.r1_rsp_rdata, 64'hDEADBEEF00000001);
    step(2);

    // r1 locks every beat while r0 contends: 4 r1, 1 r0, then r1 again.
    dut_log.delete();
    drv(1, 1, 0, 1, 8'h20, '0);
    step();
    for (int i = 0; i < 8; i++) begin
      drv(0, 1, 0, 0, 8'h30, '0);
      drv(1, 1, 0, 1, AW'(8'h21 + i), '0);
      step();
    end
    idle_all();
    chk("lock_len", dut_log.size(), 9);
    for (int i = 0; i < dut_log.size() && i < 9; i++)
      chk("lock_order", dut_log[i], e033[i]);
    step(4);

    // Random traffic over a small address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++)
        drv(k, $urandom_range(9) < 7, $urandom_range(1), $urandom_range(9) < 3,
            AW'($urandom_range(15)), {$urandom, $urandom});
      step();
    end
    idle_all();
    step(4);

    // Counter saturation on r0.
    do_reset(2);
    for (int i = 0; i < 16'hFFFE; i++) begin
      drv(0, 1, 0, 0, AW'(i), '0);
      step();
    end
    chk("sat_preload", bus.r0_grant_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 0, AW'(i), '0);
      step();
    end
    idle_all();
    chk("sat_hold", bus.r0_grant_cnt, 16'hFFFF);
    step(5);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
